// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous 256Kx16 SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } sram_state_t;

  typedef struct packed {
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [1:0]         be;
    logic [SRAM_DW-1:0] wdata;
  } sram_req_t;

  // Zero the byte lanes that were not enabled, so unselected bytes never leak stale bus data.
  function automatic logic [SRAM_DW-1:0] mask_bytes(input logic [SRAM_DW-1:0] d,
                                                     input logic [1:0]         be);
    return {d[15:8] & {8{be[1]}}, d[7:0] & {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sram_arb.sv
// Two-way request arbiter for sram_ctrl; one-hot grant, valid while advance is sampled.
// SRAM_CTRL_RR_ARB_EN selects round-robin; otherwise port 1 has fixed priority.
module sram_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

`ifdef SRAM_CTRL_RR_ARB_EN
  // Port granted most recently; the other port wins a tie.
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      last <= gnt[1];
    end
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clk, rst, advance};

  always_comb begin
    gnt = req[1] ? 2'b10 : {1'b0, req[0]};
  end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences an asynchronous 256Kx16 SRAM for two req/ack word requesters.
// Define SRAM_CTRL_RR_ARB_EN for round-robin arbitration (default: port 1 fixed priority).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [SRAM_AW-1:0] addr0,
  input  logic [SRAM_AW-1:0] addr1,
  input  logic [1:0]         be0,
  input  logic [1:0]         be1,
  input  logic [SRAM_DW-1:0] wdata0,
  input  logic [SRAM_DW-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [SRAM_DW-1:0] rdata0,
  output logic [SRAM_DW-1:0] rdata1,
  output logic               busy,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  sram_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         gnt;
  logic               advance;
  sram_req_t          sel;
  logic               cur_port;
  logic [1:0]         cur_be;
  logic               dq_oe;
  logic [SRAM_DW-1:0] dq_out;
  logic [SRAM_DW-1:0] rd_word;

  assign advance = (state == IDLE) && (req0 || req1);
  assign sel     = gnt[1] ? sram_req_t'{we: we1, addr: addr1, be: be1, wdata: wdata1}
                          : sram_req_t'{we: we0, addr: addr0, be: be0, wdata: wdata0};
  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DW{1'bz}};
  assign rd_word = mask_bytes(SRAM_DQ, cur_be);

  sram_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (advance),
    .gnt     (gnt)
  );

  // Write data and byte enables are pure datapath; they only matter once a grant has loaded them.
  always_ff @(posedge clk) begin
    if (advance) begin
      dq_out <= sel.wdata;
      cur_be <= sel.be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_port  <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      dq_oe     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (advance) begin
            cur_port  <= gnt[1];
            busy      <= 1'b1;
            SRAM_ADDR <= sel.addr;
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= ~sel.be[1];
            SRAM_LB_N <= ~sel.be[0];
            if (sel.we) begin
              dq_oe <= 1'b1;
              state <= WR_SETUP;
            end else begin
              SRAM_OE_N <= 1'b0;
              cnt       <= CNT_W'(RD_CYCLES - 1);
              state     <= RD;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            if (cur_port) rdata1 <= rd_word;
            else          rdata0 <= rd_word;
            ack0      <= ~cur_port;
            ack1      <= cur_port;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          cnt       <= CNT_W'(WR_CYCLES - 1);
          state     <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            SRAM_WE_N <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // DQ stays driven past the WE_N rising edge to cover SRAM data hold.
        WR_HOLD: begin
          dq_oe     <= 1'b0;
          ack0      <= ~cur_port;
          ack1      <= cur_port;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
